cache_seq_ctrl: RTL and testbench

CACHE_SEQ_CTRL -- requirements
Module: cache_seq_ctrl

---
 rtl/cache_pkg.sv | 28 ++
 rtl/cache_lru_table.sv | 30 +++
 rtl/cache_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cache_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types for the two-way cache sequencer: FSM encoding, default geometry and victim choice.
// Pure declarations; no timing or flow control of its own.
package cache_pkg;

    localparam int IDX_SIZE_DEF = 6;
    localparam int BLOCK_NO_DEF = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WT_WR,
        S_EVICT,
        S_FILL,
        S_REFILL
    } state_t;

    // Invalid ways are always reused first; only a full set falls back to LRU.
    function automatic logic pick_victim(input logic valid_s1, input logic valid_s2, input logic lru);
        if (!valid_s1) begin
            return 1'b0;
        end
        if (!valid_s2) begin
            return 1'b1;
        end
        return ~lru;
    endfunction

endpackage

// File: rtl/cache_lru_table.sv
// Per-set LRU bit (0 = s1 used last, 1 = s2 used last): one sync write port, one async read port.
// Write lands on the next rising edge; no backpressure.
module cache_lru_table
    import cache_pkg::*;
#(
    parameter int idx_size = IDX_SIZE_DEF,
    parameter int block_no = BLOCK_NO_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic [idx_size-1:0] waddr_i,
    input  logic                wdata_i,
    input  logic [idx_size-1:0] raddr_i,
    output logic                rdata_o
);

    logic [block_no-1:0] lru_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lru_q <= '0;
        end else if (we_i) begin
            lru_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = lru_q[raddr_i];

endmodule

// File: rtl/cache_seq_ctrl.sv
// Two-way set-associative cache controller: lookup, write-through, evict, fill and replay sequencing.
// Hit completes in two cycles; misses and write-through stall until l2_ack_i, the CPU holds its request.
module cache_seq_ctrl
    import cache_pkg::*;
#(
    parameter int idx_size = IDX_SIZE_DEF,
    parameter int block_no = BLOCK_NO_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cpu_req_i,
    input  logic                cpu_we_i,
    input  logic [idx_size-1:0] idx_i,
    input  logic                write_through_i,
    input  logic                hit_s1_i,
    input  logic                hit_s2_i,
    input  logic                valid_s1_i,
    input  logic                valid_s2_i,
    input  logic                dirty_s1_i,
    input  logic                dirty_s2_i,
    input  logic                l2_ack_i,
    output logic                cpu_done_o,
    output logic                l2_req_o,
    output logic                l2_we_o,
    output logic                we_s1_o,
    output logic                we_s2_o,
    output logic                fill_o,
    output logic                evict_way_o,
    output logic                err_o
);

    state_t              state_q, state_d;
    logic [idx_size-1:0] idx_q, idx_d;
    logic                we_q, we_d;
    logic                wt_q, wt_d;
    logic                evict_q, evict_d;
    logic                err_q, err_d;

    logic lru_we;
    logic lru_wdata;
    logic lru_rdata;
    logic any_hit;
    logic victim;
    logic victim_valid;
    logic victim_dirty;

    cache_lru_table #(
        .idx_size (idx_size),
        .block_no (block_no)
    ) u_lru (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (lru_we),
        .waddr_i (idx_q),
        .wdata_i (lru_wdata),
        .raddr_i (idx_q),
        .rdata_o (lru_rdata)
    );

    assign any_hit      = hit_s1_i | hit_s2_i;
    assign victim       = pick_victim(valid_s1_i, valid_s2_i, lru_rdata);
    assign victim_valid = victim ? valid_s2_i : valid_s1_i;
    assign victim_dirty = victim ? dirty_s2_i : dirty_s1_i;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        we_d       = we_q;
        wt_d       = wt_q;
        evict_d    = evict_q;
        err_d      = err_q;
        cpu_done_o = 1'b0;
        l2_req_o   = 1'b0;
        l2_we_o    = 1'b0;
        we_s1_o    = 1'b0;
        we_s2_o    = 1'b0;
        fill_o     = 1'b0;
        lru_we     = 1'b0;
        lru_wdata  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req_i) begin
                    state_d = S_LOOKUP;
                    idx_d   = idx_i;
                    we_d    = cpu_we_i;
                    wt_d    = write_through_i;
                end
            end
            S_LOOKUP: begin
                if (any_hit) begin
                    // A double hit is resolved as s1 so the array write stays one-hot.
                    lru_we    = 1'b1;
                    lru_wdata = ~hit_s1_i;
                    if (hit_s1_i && hit_s2_i) begin
                        err_d = 1'b1;
                    end
                    if (we_q) begin
                        we_s1_o = hit_s1_i;
                        we_s2_o = ~hit_s1_i;
                    end
                    if (we_q && wt_q) begin
                        state_d = S_WT_WR;
                    end else begin
                        cpu_done_o = 1'b1;
                        state_d    = S_IDLE;
                    end
                end else begin
                    evict_d = victim;
                    state_d = (victim_valid && victim_dirty && !wt_q) ? S_EVICT : S_FILL;
                end
            end
            S_WT_WR: begin
                l2_req_o = 1'b1;
                l2_we_o  = 1'b1;
                if (l2_ack_i) begin
                    cpu_done_o = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_EVICT: begin
                l2_req_o = 1'b1;
                l2_we_o  = 1'b1;
                if (l2_ack_i) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                l2_req_o = 1'b1;
                if (l2_ack_i) begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                // Replay through LOOKUP so the original access completes as an ordinary hit.
                we_s1_o = ~evict_q;
                we_s2_o = evict_q;
                fill_o  = 1'b1;
                state_d = S_LOOKUP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wt_q    <= 1'b0;
            evict_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wt_q    <= wt_d;
            evict_q <= evict_d;
            err_q   <= err_d;
        end
    end

    assign evict_way_o = evict_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_cache_seq_ctrl.sv
// Directed bench for cache_seq_ctrl: expected per-cycle output vectors are queued before each access
// and a negedge monitor pops one for every cycle in which the DUT shows any activity.
module tb_cache_seq_ctrl;
    import cache_pkg::*;

    localparam int IW = IDX_SIZE_DEF;
    localparam int NB = BLOCK_NO_DEF;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          cpu_req_i = 1'b0;
    logic          cpu_we_i = 1'b0;
    logic [IW-1:0] idx_i = '0;
    logic          write_through_i = 1'b0;
    logic          hit_s1_i, hit_s2_i, valid_s1_i, valid_s2_i, dirty_s1_i, dirty_s2_i;
    logic          l2_ack_i = 1'b0;
    logic          cpu_done_o, l2_req_o, l2_we_o, we_s1_o, we_s2_o, fill_o, evict_way_o, err_o;

    // Environment model of the tag/valid/dirty arrays; m1/m2 = way holds the requested line.
    logic [NB-1:0] m1 = '0, m2 = '0, v1 = '0, v2 = '0, d1 = '0, d2 = '0;
    logic          cur_wt = 1'b0;
    logic          spur = 1'b0;
    int            ack_delay = 0;
    int            req_cyc = 0;

    logic [7:0]    sb[$];
    logic [7:0]    mon_got, mon_exp;
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    assign hit_s1_i   = m1[idx_i];
    assign hit_s2_i   = m2[idx_i];
    assign valid_s1_i = v1[idx_i];
    assign valid_s2_i = v2[idx_i];
    assign dirty_s1_i = d1[idx_i];
    assign dirty_s2_i = d2[idx_i];

    cache_seq_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .cpu_req_i       (cpu_req_i),
        .cpu_we_i        (cpu_we_i),
        .idx_i           (idx_i),
        .write_through_i (write_through_i),
        .hit_s1_i        (hit_s1_i),
        .hit_s2_i        (hit_s2_i),
        .valid_s1_i      (valid_s1_i),
        .valid_s2_i      (valid_s2_i),
        .dirty_s1_i      (dirty_s1_i),
        .dirty_s2_i      (dirty_s2_i),
        .l2_ack_i        (l2_ack_i),
        .cpu_done_o      (cpu_done_o),
        .l2_req_o        (l2_req_o),
        .l2_we_o         (l2_we_o),
        .we_s1_o         (we_s1_o),
        .we_s2_o         (we_s2_o),
        .fill_o          (fill_o),
        .evict_way_o     (evict_way_o),
        .err_o           (err_o)
    );

    // Vector layout: {cpu_done, l2_req, l2_we, we_s1, we_s2, fill, evict_way, err}
    function automatic logic [7:0] ev(input logic done, input logic rq, input logic rw, input logic w1,
                                      input logic w2, input logic fl, input logic evw, input logic er);
        return {done, rq, rw, w1, w2, fl, evw, er};
    endfunction

    task automatic push(input logic [7:0] e, input int n);
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // L2 model: acks on the (ack_delay+1)-th cycle of each continuous request phase.
    always @(posedge clk) begin
        #1;
        if (l2_req_o) begin
            l2_ack_i = (req_cyc == ack_delay);
            req_cyc  = (req_cyc == ack_delay) ? 0 : req_cyc + 1;
        end else begin
            l2_ack_i = spur;
            req_cyc  = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst_i && (cpu_done_o || l2_req_o || we_s1_o || we_s2_o || fill_o)) begin
            mon_got = {cpu_done_o, l2_req_o, l2_we_o, we_s1_o, we_s2_o, fill_o, evict_way_o, err_o};
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: got %b expected none", mon_got);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    n_err++;
                    $display("FAIL event: got %b expected %b", mon_got, mon_exp);
                end
            end
            if (we_s1_o) begin
                if (fill_o) begin
                    m1[idx_i] = 1'b1; v1[idx_i] = 1'b1; d1[idx_i] = 1'b0;
                end else if (!cur_wt) begin
                    d1[idx_i] = 1'b1;
                end
            end
            if (we_s2_o) begin
                if (fill_o) begin
                    m2[idx_i] = 1'b1; v2[idx_i] = 1'b1; d2[idx_i] = 1'b0;
                end else if (!cur_wt) begin
                    d2[idx_i] = 1'b1;
                end
            end
        end
    end

    task automatic do_req(input logic [IW-1:0] idx, input logic we, input logic wt, input int dly, input int drop);
        logic done_ok;
        @(posedge clk); #1;
        idx_i = idx; cpu_we_i = we; write_through_i = wt; cur_wt = wt; ack_delay = dly;
        cpu_req_i = 1'b1;
        done_ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (cpu_done_o) begin
                done_ok = 1'b1;
                break;
            end
            if (drop > 0 && c == drop) cpu_req_i = 1'b0;
        end
        if (!done_ok) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: got no cpu_done_o expected pulse (set %0d)", idx);
        end
        @(posedge clk); #1;
        cpu_req_i = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #1 rst_i = 1'b1;
        #2;
        check("rst_state", 64'(dut.state_q), 64'(S_IDLE));
        check("rst_outs", 64'({cpu_done_o, l2_req_o, l2_we_o, we_s1_o, we_s2_o, fill_o, evict_way_o, err_o}), 64'd0);
        check("rst_lru", 64'(dut.u_lru.lru_q), 64'd0);
        @(posedge clk); #1 rst_i = 1'b0;

        // Write miss, both ways invalid: fill into s1, replay writes CPU data.
        push(ev(0,1,0,0,0,0,0,0), 2);
        push(ev(0,0,0,1,0,1,0,0), 1);
        push(ev(1,0,0,1,0,0,0,0), 1);
        do_req(IW'(5), 1'b1, 1'b0, 1, 0);
        check("lru5_s1", 64'(dut.u_lru.lru_q[5]), 64'd0);

        // Set 3: s1 read hit, then a miss evicts dirty s2 before the fill.
        v1[3] = 1'b1; v2[3] = 1'b1; d2[3] = 1'b1; m1[3] = 1'b1;
        push(ev(1,0,0,0,0,0,0,0), 1);
        do_req(IW'(3), 1'b0, 1'b0, 0, 0);
        check("lru3_after_s1", 64'(dut.u_lru.lru_q[3]), 64'd0);
        m1[3] = 1'b0;
        push(ev(0,1,1,0,0,0,1,0), 2);
        push(ev(0,1,0,0,0,0,1,0), 2);
        push(ev(0,0,0,0,1,1,1,0), 1);
        push(ev(1,0,0,0,0,0,1,0), 1);
        do_req(IW'(3), 1'b0, 1'b0, 1, 0);
        check("evict_way_set3", 64'(evict_way_o), 64'd1);
        check("lru3_after_s2", 64'(dut.u_lru.lru_q[3]), 64'd1);

        // Write-through write hit on s2 with the ack four cycles late.
        push(ev(0,0,0,0,1,0,1,0), 1);
        push(ev(0,1,1,0,0,0,1,0), 4);
        push(ev(1,1,1,0,0,0,1,0), 1);
        do_req(IW'(3), 1'b1, 1'b1, 4, 0);

        // Write-through miss on a dirty victim skips eviction; immediate acks.
        v1[9] = 1'b1; d1[9] = 1'b1; v2[9] = 1'b1; d2[9] = 1'b1;
        push(ev(0,1,0,0,0,0,1,0), 1);
        push(ev(0,0,0,0,1,1,1,0), 1);
        push(ev(0,0,0,0,1,0,1,0), 1);
        push(ev(1,1,1,0,0,0,1,0), 1);
        do_req(IW'(9), 1'b1, 1'b1, 0, 0);

        // s2 invalid victim; CPU drops its request mid-miss.
        v1[12] = 1'b1;
        push(ev(0,1,0,0,0,0,1,0), 3);
        push(ev(0,0,0,0,1,1,1,0), 1);
        push(ev(1,0,0,0,0,0,1,0), 1);
        do_req(IW'(12), 1'b0, 1'b0, 2, 2);

        // Full set with LRU = s2 picks s1.
        m2[3] = 1'b0;
        push(ev(0,1,0,0,0,0,0,0), 1);
        push(ev(0,0,0,1,0,1,0,0), 1);
        push(ev(1,0,0,0,0,0,0,0), 1);
        do_req(IW'(3), 1'b0, 1'b0, 0, 0);
        check("evict_way_lru", 64'(evict_way_o), 64'd0);

        // Double hit: treated as s1, error becomes sticky.
        v1[20] = 1'b1; v2[20] = 1'b1; m2[20] = 1'b1;
        push(ev(1,0,0,0,0,0,0,0), 1);
        do_req(IW'(20), 1'b0, 1'b0, 0, 0);
        check("lru20_s2", 64'(dut.u_lru.lru_q[20]), 64'd1);
        m1[20] = 1'b1;
        push(ev(1,0,0,0,0,0,0,0), 1);
        do_req(IW'(20), 1'b0, 1'b0, 0, 0);
        check("err_set", 64'(err_o), 64'd1);
        check("lru20_dbl", 64'(dut.u_lru.lru_q[20]), 64'd0);
        m1[20] = 1'b0; m2[20] = 1'b0;
        push(ev(0,1,0,0,0,0,1,1), 1);
        push(ev(0,0,0,0,1,1,1,1), 1);
        push(ev(1,0,0,0,0,0,1,1), 1);
        do_req(IW'(20), 1'b0, 1'b0, 0, 0);
        check("err_sticky", 64'(err_o), 64'd1);

        // Stray acks with no request outstanding must do nothing.
        spur = 1'b1;
        repeat (4) @(posedge clk);
        spur = 1'b0;
        repeat (2) @(posedge clk);
        check("spur_state", 64'(dut.state_q), 64'(S_IDLE));
        check("sb_drain_mid", 64'(sb.size()), 64'd0);

        // Reset in the middle of a long fill.
        @(posedge clk); #1;
        idx_i = IW'(30); cpu_we_i = 1'b0; write_through_i = 1'b0; cur_wt = 1'b0; ack_delay = 10;
        cpu_req_i = 1'b1;
        push(ev(0,1,0,0,0,0,0,1), 2);
        repeat (4) @(posedge clk);
        #2;
        check("pre_rst_l2_req", 64'(l2_req_o), 64'd1);
        rst_i = 1'b1; cpu_req_i = 1'b0;
        #1;
        check("rst_l2_req", 64'(l2_req_o), 64'd0);
        check("rst_mid_outs", 64'({cpu_done_o, l2_we_o, we_s1_o, we_s2_o, fill_o, evict_way_o, err_o}), 64'd0);
        check("rst_mid_state", 64'(dut.state_q), 64'(S_IDLE));
        check("rst_mid_lru", 64'(dut.u_lru.lru_q), 64'd0);
        check("sb_drain_rst", 64'(sb.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0; ack_delay = 0;

        // Plain read hit after reset: error flag cleared.
        push(ev(1,0,0,0,0,0,0,0), 1);
        do_req(IW'(5), 1'b0, 1'b0, 0, 0);
        check("err_after_rst", 64'(err_o), 64'd0);

        repeat (3) @(posedge clk);
        check("sb_drain_end", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
